// File: rtl/mem_stage_ctrl.sv
// rtl/mem_stage_ctrl.sv - memory-stage controller driving the dcache request interface
module mem_stage_ctrl #(
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 32
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             dmemREN_in,
  input  logic             dmemWEN_in,
  input  logic [31:0]      addr_in,
  input  logic [31:0]      store_in,
  input  logic             halt_in,
  input  logic             dhit,
  input  logic [31:0]      dload,
  input  logic             flushdone,
  output logic             dREN,
  output logic             dWEN,
  output logic [31:0]      daddr,
  output logic [31:0]      dstore,
  output logic [31:0]      load_data,
  output logic             latch_wen,
  output logic             dflush,
  output logic             halt_out,
  output logic             err,
  output logic [CNT_W-1:0] stall_cnt
);

  typedef enum logic [1:0] {IDLE, ACCESS, FLUSH, HALTED} state_t;

  localparam logic [15:0] TO_LIM = 16'(TIMEOUT);

  state_t      state;
  logic [15:0] wait_cnt;
  logic        req_ren;
  logic        req_wen;
  logic        req_valid;
  logic        req_bad;
  logic        timed_out;

  // Request classification and the ACCESS-state abort condition.
  always_comb begin
    req_valid = (dmemREN_in ^ dmemWEN_in) && (addr_in[1:0] == 2'b00);
    req_bad   = (dmemREN_in & dmemWEN_in) |
                ((dmemREN_in | dmemWEN_in) & (addr_in[1:0] != 2'b00));
    timed_out = (wait_cnt == TO_LIM);
  end

  // Cache strobes and pipeline hold; all quiet while reset is held so an
  // in-flight access is abandoned the moment nRST falls.
  always_comb begin
    dREN      = 1'b0;
    dWEN      = 1'b0;
    latch_wen = 1'b1;
    if (nRST) begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            dREN      = dmemREN_in;
            dWEN      = dmemWEN_in;
            latch_wen = dhit;
          end else if (halt_in) begin
            latch_wen = 1'b0;
          end
        end
        ACCESS: begin
          dREN      = req_ren;
          dWEN      = req_wen;
          latch_wen = dhit | timed_out;
        end
        default: latch_wen = 1'b0;
      endcase
    end
  end

  // Address/data are word-aligned and zeroed whenever no access is driven.
  always_comb begin
    daddr  = (dREN | dWEN) ? {addr_in[31:2], 2'b00} : 32'h0;
    dstore = (dREN | dWEN) ? store_in : 32'h0;
    dflush = nRST && (state == FLUSH);
  end

  // Main sequencer: access tracking, halt/flush sequence, sticky flags and stall counter.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state     <= IDLE;
      wait_cnt  <= 16'd0;
      req_ren   <= 1'b0;
      req_wen   <= 1'b0;
      load_data <= 32'h0;
      err       <= 1'b0;
      halt_out  <= 1'b0;
      stall_cnt <= '0;
    end else begin
      if (!latch_wen && (stall_cnt != {CNT_W{1'b1}}))
        stall_cnt <= stall_cnt + CNT_W'(1);

      case (state)
        IDLE: begin
          if (req_valid) begin
            if (dhit) begin
              if (dmemREN_in)
                load_data <= dload;
            end else begin
              req_ren  <= dmemREN_in;
              req_wen  <= dmemWEN_in;
              wait_cnt <= 16'd1;
              state    <= ACCESS;
            end
          end else begin
            if (req_bad)
              err <= 1'b1;
            if (halt_in)
              state <= FLUSH;
          end
        end
        ACCESS: begin
          if (dhit) begin
            if (req_ren)
              load_data <= dload;
            req_ren  <= 1'b0;
            req_wen  <= 1'b0;
            wait_cnt <= 16'd0;
            state    <= IDLE;
          end else if (timed_out) begin
            err      <= 1'b1;
            req_ren  <= 1'b0;
            req_wen  <= 1'b0;
            wait_cnt <= 16'd0;
            state    <= IDLE;
          end else begin
            wait_cnt <= wait_cnt + 16'd1;
          end
        end
        FLUSH: begin
          if (flushdone) begin
            halt_out <= 1'b1;
            state    <= HALTED;
          end
        end
        default: halt_out <= 1'b1;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// tb/tb_mem_stage_ctrl.sv - directed self-checking bench for mem_stage_ctrl
module tb_mem_stage_ctrl;

  logic        CLK;
  logic        nRST;
  logic        dmemREN_in;
  logic        dmemWEN_in;
  logic [31:0] addr_in;
  logic [31:0] store_in;
  logic        halt_in;
  logic        dhit;
  logic [31:0] dload;
  logic        flushdone;
  logic        dREN;
  logic        dWEN;
  logic [31:0] daddr;
  logic [31:0] dstore;
  logic [31:0] load_data;
  logic        latch_wen;
  logic        dflush;
  logic        halt_out;
  logic        err;
  logic [3:0]  stall_cnt;

  int checks;
  int failures;

  mem_stage_ctrl #(.TIMEOUT(4), .CNT_W(4)) dut (
    .CLK(CLK), .nRST(nRST),
    .dmemREN_in(dmemREN_in), .dmemWEN_in(dmemWEN_in),
    .addr_in(addr_in), .store_in(store_in), .halt_in(halt_in),
    .dhit(dhit), .dload(dload), .flushdone(flushdone),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .load_data(load_data), .latch_wen(latch_wen), .dflush(dflush),
    .halt_out(halt_out), .err(err), .stall_cnt(stall_cnt)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle_inputs();
    dmemREN_in = 1'b0;
    dmemWEN_in = 1'b0;
    addr_in    = 32'h0;
    store_in   = 32'h0;
    halt_in    = 1'b0;
    dhit       = 1'b0;
    dload      = 32'h0;
    flushdone  = 1'b0;
  endtask

  task automatic do_reset();
    nRST = 1'b0;
    #3;
    nRST = 1'b1;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    idle_inputs();
    nRST = 1'b0;
    #12;
    chk("rst_dREN", dREN, 0);
    chk("rst_dWEN", dWEN, 0);
    chk("rst_latch", latch_wen, 1);
    chk("rst_dflush", dflush, 0);
    chk("rst_halt", halt_out, 0);
    chk("rst_err", err, 0);
    chk("rst_load", load_data, 0);
    chk("rst_stall", stall_cnt, 0);
    chk("rst_daddr", daddr, 0);
    nRST = 1'b1;
    tick();

    // zero-wait load hit
    dmemREN_in = 1'b1; addr_in = 32'h100; dhit = 1'b1; dload = 32'hDEADBEEF;
    #1;
    chk("ld0_dREN", dREN, 1);
    chk("ld0_dWEN", dWEN, 0);
    chk("ld0_daddr", daddr, 32'h100);
    chk("ld0_latch", latch_wen, 1);
    tick();
    idle_inputs();
    #1;
    chk("ld0_data", load_data, 32'hDEADBEEF);
    chk("ld0_stall", stall_cnt, 0);
    chk("ld0_idle_dREN", dREN, 0);
    chk("ld0_idle_daddr", daddr, 0);

    // store with hit on third cycle
    tick();
    dmemWEN_in = 1'b1; addr_in = 32'h204; store_in = 32'h12345678;
    #1;
    chk("st_c0_dWEN", dWEN, 1);
    chk("st_c0_latch", latch_wen, 0);
    chk("st_c0_daddr", daddr, 32'h204);
    chk("st_c0_dstore", dstore, 32'h12345678);
    tick();
    chk("st_c1_dWEN", dWEN, 1);
    chk("st_c1_latch", latch_wen, 0);
    tick();
    dhit = 1'b1;
    #1;
    chk("st_c2_dWEN", dWEN, 1);
    chk("st_c2_latch", latch_wen, 1);
    tick();
    idle_inputs();
    #1;
    chk("st_stall", stall_cnt, 2);
    chk("st_load_kept", load_data, 32'hDEADBEEF);
    chk("st_done_dWEN", dWEN, 0);
    chk("st_done_latch", latch_wen, 1);
    chk("st_err", err, 0);

    // misaligned then illegal read+write
    dmemREN_in = 1'b1; addr_in = 32'h102;
    #1;
    chk("mis_dREN", dREN, 0);
    chk("mis_latch", latch_wen, 1);
    chk("mis_daddr", daddr, 0);
    chk("mis_err_pre", err, 0);
    tick();
    chk("mis_err", err, 1);
    dmemWEN_in = 1'b1; addr_in = 32'h100;
    #1;
    chk("ill_dREN", dREN, 0);
    chk("ill_dWEN", dWEN, 0);
    chk("ill_latch", latch_wen, 1);
    tick();
    idle_inputs();
    #1;
    chk("ill_err_sticky", err, 1);
    chk("ill_stall", stall_cnt, 2);
    do_reset();
    #1;
    chk("rst2_err", err, 0);
    chk("rst2_load", load_data, 0);

    // one-wait load completes from ACCESS
    tick();
    dmemREN_in = 1'b1; addr_in = 32'h300;
    #1;
    chk("ld1_c0_latch", latch_wen, 0);
    tick();
    dhit = 1'b1; dload = 32'hCAFEF00D;
    #1;
    chk("ld1_c1_dREN", dREN, 1);
    chk("ld1_c1_latch", latch_wen, 1);
    tick();
    idle_inputs();
    #1;
    chk("ld1_data", load_data, 32'hCAFEF00D);
    chk("ld1_stall", stall_cnt, 1);

    // timeout with TIMEOUT = 4
    dmemREN_in = 1'b1; addr_in = 32'h40;
    #1;
    chk("to_c0_latch", latch_wen, 0);
    chk("to_c0_dREN", dREN, 1);
    for (int i = 1; i < 4; i++) begin
      tick();
      chk($sformatf("to_c%0d_latch", i), latch_wen, 0);
      chk($sformatf("to_c%0d_dREN", i), dREN, 1);
      chk($sformatf("to_c%0d_err", i), err, 0);
    end
    tick();
    chk("to_c4_latch", latch_wen, 1);
    tick();
    idle_inputs();
    #1;
    chk("to_err", err, 1);
    chk("to_dREN", dREN, 0);
    chk("to_latch", latch_wen, 1);
    chk("to_stall", stall_cnt, 5);
    chk("to_load_kept", load_data, 32'hCAFEF00D);

    // reset while an access is outstanding
    dmemREN_in = 1'b1; addr_in = 32'h80;
    tick();
    chk("ra_pre_latch", latch_wen, 0);
    chk("ra_pre_stall", stall_cnt, 6);
    nRST = 1'b0;
    #1;
    chk("ra_dREN", dREN, 0);
    chk("ra_latch", latch_wen, 1);
    chk("ra_err", err, 0);
    chk("ra_stall", stall_cnt, 0);
    idle_inputs();
    #1;
    nRST = 1'b1;

    // halt: flush for five cycles, then stuck halted
    tick();
    halt_in = 1'b1;
    #1;
    chk("h_c0_latch", latch_wen, 0);
    chk("h_c0_dflush", dflush, 0);
    tick();
    for (int i = 1; i <= 5; i++) begin
      flushdone = (i == 5);
      #1;
      chk($sformatf("h_c%0d_dflush", i), dflush, 1);
      chk($sformatf("h_c%0d_latch", i), latch_wen, 0);
      chk($sformatf("h_c%0d_halt", i), halt_out, 0);
      tick();
    end
    flushdone = 1'b0;
    halt_in   = 1'b0;
    #1;
    chk("h_halt", halt_out, 1);
    chk("h_dflush_off", dflush, 0);
    chk("h_latch", latch_wen, 0);
    chk("h_stall", stall_cnt, 6);
    for (int i = 0; i < 20; i++) tick();
    chk("h_stall_sat", stall_cnt, 4'hF);
    chk("h_halt_sticky", halt_out, 1);
    chk("h_latch_stuck", latch_wen, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_stage_ctrl.md
Name: mem_stage_ctrl

Overview:
Memory-stage controller that consumes the EX/MEM pipeline register outputs and drives the data-cache request interface. It holds the pipeline by deasserting the EX/MEM latch write enable while an access is outstanding, and returns load data toward MEM/WB. It also runs the halt sequence, which flushes the dcache and then asserts a sticky halt. It guards against misaligned addresses, illegal read+write combinations, and hung accesses.

Parameters:
TIMEOUT, 255, max cycles an access may wait for dhit before abort (1..65535)
CNT_W, 32, width of stall-cycle performance counter

Ports:
CLK  input  1  clock, rising edge
nRST  input  1  asynchronous active-low reset
dmemREN_in  input  1  load request from EX/MEM register
dmemWEN_in  input  1  store request from EX/MEM register
addr_in  input  32  ALU result (byte address) from EX/MEM register
store_in  input  32  store data (rdat2) from EX/MEM register
halt_in  input  1  halt from EX/MEM register
dhit  input  1  dcache access complete this cycle
dload  input  32  dcache read data, valid when dhit
flushdone  input  1  dcache flush complete
dREN  output  1  dcache read request
dWEN  output  1  dcache write request
daddr  output  32  dcache word address
dstore  output  32  dcache write data
load_data  output  32  registered load result
latch_wen  output  1  EX/MEM and upstream latch write enable (0 = stall)
dflush  output  1  dcache flush request
halt_out  output  1  sticky halted indication
err  output  1  sticky error (misalign / illegal / timeout)
stall_cnt  output  CNT_W  saturating count of cycles with latch_wen = 0

Behaviour:
- Reset (async, nRST = 0): state = IDLE. dREN, dWEN, dflush, halt_out, err = 0. load_data, stall_cnt, wait counter = 0. latch_wen = 1. daddr and dstore = 0. Reset mid-access abandons the access immediately.
- daddr = {addr_in[31:2], 2'b00}; dstore = store_in. Both outputs are combinational and forced to 0 whenever dREN = dWEN = 0.
- Request is valid when exactly one of dmemREN_in and dmemWEN_in is 1 and addr_in[1:0] = 0.
- Invalid request: both enables 1, or either enable 1 with addr_in[1:0] != 0. Sets err at the next edge. No dcache access is made, latch_wen stays 1, and the instruction passes as a no-op.
- States: IDLE, ACCESS, FLUSH, HALTED.
- IDLE:
  - Valid request: dREN/dWEN follow the inputs combinationally in the same cycle.
  - If dhit = 1 in that cycle: latch_wen = 1, load_data <= dload if it is a load, state stays IDLE (zero-wait access).
  - Else: latch_wen = 0, wait counter <= 1, state -> ACCESS.
  - Else if halt_in = 1: latch_wen = 0, state -> FLUSH.
  - Memory op takes priority over halt_in in the same cycle; halt is handled once the access completes.
- ACCESS:
  - dREN/dWEN are held from the latched inputs, which remain stable because latch_wen = 0.
  - On dhit: latch_wen = 1 in that cycle, load_data <= dload on a load, state -> IDLE.
  - If the wait counter reaches TIMEOUT with no dhit: err <= 1, drop the request, latch_wen = 1 for one cycle, state -> IDLE.
  - Otherwise the wait counter increments.
- FLUSH: dflush = 1 and latch_wen = 0. On flushdone: halt_out <= 1, state -> HALTED.
- HALTED: latch_wen = 0, dflush = 0, halt_out = 1. Leaves only on reset.
- load_data holds its value until the next completed load; stores do not change it.
- stall_cnt increments at each edge where latch_wen = 0 and saturates at all-ones.
- err is sticky until reset.

Test Plan:
- Load hit, 0 wait: dmemREN_in = 1, addr_in = 0x100, dhit = 1 same cycle, dload = 0xDEADBEEF -> dREN = 1, daddr = 0x100, latch_wen = 1 throughout, load_data = 0xDEADBEEF next edge, stall_cnt = 0.
- Store with 3-cycle miss: dmemWEN_in = 1, addr_in = 0x204, store_in = 0x12345678, dhit on cycle 3 -> dWEN = 1 for 3 cycles, latch_wen = 0 for cycles 0-1 and 1 on cycle 2, stall_cnt = 2, load_data unchanged.
- Misaligned / illegal: dmemREN_in = 1 with addr_in = 0x102, then REN = WEN = 1 -> no dREN/dWEN, latch_wen = 1, err = 1 after the first edge and stays 1.
- Timeout: TIMEOUT = 4, load to 0x40, dhit never asserted -> latch_wen = 0 for 4 cycles, then err = 1, dREN drops, latch_wen = 1, state returns to IDLE.
- Halt: halt_in = 1, flushdone asserted 5 cycles later -> dflush = 1 for 5 cycles, halt_out = 1 after flushdone edge, latch_wen stuck at 0, dflush = 0 afterwards.
- Reset mid-access: nRST pulled low during ACCESS -> dREN = 0, latch_wen = 1, err = 0, stall_cnt = 0 immediately (asynchronous).
